flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Producer end of the condition-flag interface. Computes C, L, F, N and Z from execute-stage operands and holds them in the processor status register (PSR).
- Drives the flag inputs of the condition decoder and the PSR read path.
- Also owns the interrupt-enable bit E and a one-deep PSR shadow used for interrupt entry and return.

Parameters:
WIDTH, 16, operand width; must be 16 so the PSR maps onto a register
PSR_MASK, 16'h02E5, writable PSR bits (C0, L2, F5, Z6, N7, E9); all other bits read 0

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  pipeline hold; suppresses every state update
op_valid  in  1  op_class/a/b are valid this cycle
op_class  in  3  flag operation (see Decomposition)
a  in  WIDTH  Rdest operand
b  in  WIDTH  Rsrc operand (or immediate)
irq_entry  in  1  interrupt accepted: save PSR, clear E
irq_return  in  1  RETX: restore PSR from shadow
C, L, F, N, Z  out  1 each  registered flags to the condition decoder
E  out  1  interrupt enable
psr  out  WIDTH  {flags at PSR bit positions, others 0}, for SPR

Behaviour:
- Reset (async): PSR = 0, shadow = 0. All outputs 0.
- Latency: an op accepted in cycle N is visible on the outputs in cycle N+1. Back-to-back ops see the previous op's committed flags.
- Accept condition: op_valid && !stall. With stall=1, PSR and shadow hold regardless of any other input.
- Update priority per cycle:
  - reset
  - stall (hold)
  - irq_return: PSR <= shadow
  - irq_entry: shadow <= current PSR; E <= 0; the same-cycle op is dropped
  - accepted op
- ADD: sum = a + b in WIDTH+1 bits.
  - C = sum[WIDTH].
  - F = signed overflow: a and b have the same sign and the result sign differs.
  - L, N, Z, E unchanged.
- ADDC: as ADD with carry-in = registered C.
- SUB: diff = a - b.
  - C = borrow, i.e. (b > a) unsigned.
  - F = signed overflow: a and b have different signs and the result sign differs from a.
  - Others unchanged.
- SUBC: a - b - C, with the same C and F rules. A borrow-in makes C=1 when a == b.
- CMP:
  - Z = (a == b).
  - L = (b > a) unsigned.
  - N = (b > a) signed.
  - C, F, E unchanged.
- LPR: PSR <= a & PSR_MASK.
- EDI: E <= b[0]; flags unchanged.
- NONE, or op_valid=0: no change.
- The shadow is written only by irq_entry.
- irq_entry and irq_return asserted together: irq_return wins, and the shadow is not rewritten.
- Nested irq_entry with no return between: the shadow is overwritten and the older state is lost. This is documented, not an error.
- Reset mid-operation clears immediately, with no pending update.

Optional Feature:
- Macro: FLAG_FWD_EN.
- Defined:
  - C/L/F/N/Z/E become combinational next-state values: the PSR D-input after priority resolution, which equals the PSR when nothing is accepted.
  - This lets the decoder evaluate a branch in the same cycle as the preceding CMP, with zero latency.
  - psr output stays registered.
- Undefined:
  - All outputs come from the PSR register with one-cycle latency.
  - The stage must insert one bubble between a flag-setting op and a dependent branch.

Decomposition:
- defines.v (shared constants):
  - op_class codes: NONE=0, ADD=1, ADDC=2, SUB=3, SUBC=4, CMP=5, LPR=6, EDI=7.
  - PSR bit positions: PSR_C=0, PSR_L=2, PSR_F=5, PSR_Z=6, PSR_N=7, PSR_E=9.
- Sub-module flag_calc: purely combinational next-flag computation from op_class, a, b and the current flags. It is reused by the forwarding path.
- flag_unit holds the PSR, the shadow, the priority logic and the output muxing.

Test Plan:
- CMP with a=16'h0003, b=16'h0005 → next cycle Z=0, L=1, N=1; with a=b=16'h8000 → Z=1, L=0, N=0.
- CMP with a=16'h0001, b=16'hFFFF → L=1, N=0, checking that the signed and unsigned results differ.
- ADD 16'hFFFF+16'h0001 → C=1, F=0. Then ADDC 16'h7FFF+16'h0000 using carry 1 → C=0, F=1, and L/N/Z unchanged.
- SUB: a=16'h8000, b=16'h0001 → C=0, F=1.
- SUBC: a=b=16'h0010 with C=1 → C=1.
- LPR a=16'hFFFF → psr=16'h02E5. Then an op with stall=1 → psr holds. Release stall → update applies one cycle later.
- EDI b[0]=1 → E=1. Then:
  - irq_entry with a simultaneous CMP → E=0, CMP dropped, shadow=16'h0200|flags.
  - irq_return → psr restored exactly.
  - Assert reset mid-sequence → all outputs 0 immediately.
- With FLAG_FWD_EN: CMP a=b → Z=1 in the same cycle. Without it: Z=1 one cycle later.

Source files
------------

// File: rtl/flag_unit_pkg.sv
// Shared constants for the condition-flag producer: op_class codes and PSR bit positions.
package flag_unit_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_ADDC = 3'd2,
        OP_SUB  = 3'd3,
        OP_SUBC = 3'd4,
        OP_CMP  = 3'd5,
        OP_LPR  = 3'd6,
        OP_EDI  = 3'd7
    } op_class_t;

    localparam int unsigned PSR_C = 0;
    localparam int unsigned PSR_L = 2;
    localparam int unsigned PSR_F = 5;
    localparam int unsigned PSR_Z = 6;
    localparam int unsigned PSR_N = 7;
    localparam int unsigned PSR_E = 9;

endpackage

// File: rtl/flag_unit_if.sv
// Execute-stage <-> flag unit bundle: op/irq controls in, registered flags and PSR out.
interface flag_unit_if
    import flag_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    logic             stall;
    logic             op_valid;
    op_class_t        op_class;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             irq_entry;
    logic             irq_return;
    logic             C;
    logic             L;
    logic             F;
    logic             N;
    logic             Z;
    logic             E;
    logic [WIDTH-1:0] psr;

    modport master (
        output stall, op_valid, op_class, a, b, irq_entry, irq_return,
        input  C, L, F, N, Z, E, psr
    );

    modport slave (
        input  stall, op_valid, op_class, a, b, irq_entry, irq_return,
        output C, L, F, N, Z, E, psr
    );
endinterface

// File: rtl/flag_unit_calc.sv
// Combinational next-PSR computation for one flag operation; shared by the
// registered path and the forwarding path of flag_unit.
module flag_calc
    import flag_unit_pkg::*;
#(
    parameter int unsigned     WIDTH    = 16,
    parameter logic [WIDTH-1:0] PSR_MASK = 16'h02E5
) (
    input  op_class_t        op_class,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);
    logic       cin;
    logic [1:0] add_top;
    logic [1:0] sub_top;

    // Only the carry/borrow bit and the result sign matter, so the
    // WIDTH+1-bit result is shifted down to its top two bits.
    always_comb begin
        nxt     = cur;
        cin     = 1'b0;
        add_top = '0;
        sub_top = '0;
        case (op_class)
            OP_ADD, OP_ADDC: begin
                cin        = (op_class == OP_ADDC) && cur[PSR_C];
                add_top    = 2'(({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin}) >> (WIDTH - 1));
                nxt[PSR_C] = add_top[1];
                nxt[PSR_F] = (a[WIDTH-1] == b[WIDTH-1]) && (add_top[0] != a[WIDTH-1]);
            end
            OP_SUB, OP_SUBC: begin
                cin        = (op_class == OP_SUBC) && cur[PSR_C];
                sub_top    = 2'(({1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin}) >> (WIDTH - 1));
                nxt[PSR_C] = sub_top[1];
                nxt[PSR_F] = (a[WIDTH-1] != b[WIDTH-1]) && (sub_top[0] != a[WIDTH-1]);
            end
            OP_CMP: begin
                nxt[PSR_Z] = (a == b);
                nxt[PSR_L] = (b > a);
                nxt[PSR_N] = ($signed(b) > $signed(a));
            end
            OP_LPR:  nxt = a & PSR_MASK;
            OP_EDI:  nxt[PSR_E] = b[0];
            default: ;
        endcase
    end
endmodule

// File: rtl/flag_unit.sv
// Processor status register with interrupt shadow and flag outputs.
// Define FLAG_FWD_EN to drive the flags from the PSR next-state (zero latency).
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] PSR_MASK = 16'h02E5
) (
    input  logic       clk,
    input  logic       reset,
    flag_unit_if.slave bus
);
    logic [WIDTH-1:0] psr_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] psr_op;
    logic [WIDTH-1:0] psr_d;
    logic [WIDTH-1:0] shadow_d;

    flag_calc #(
        .WIDTH    (WIDTH),
        .PSR_MASK (PSR_MASK)
    ) u_calc (
        .op_class (bus.op_class),
        .a        (bus.a),
        .b        (bus.b),
        .cur      (psr_q),
        .nxt      (psr_op)
    );

    // irq_return outranks irq_entry so a coincident pair never rewrites the shadow.
    always_comb begin
        psr_d    = psr_q;
        shadow_d = shadow_q;
        if (!bus.stall) begin
            if (bus.irq_return) begin
                psr_d = shadow_q;
            end else if (bus.irq_entry) begin
                shadow_d     = psr_q;
                psr_d[PSR_E] = 1'b0;
            end else if (bus.op_valid) begin
                psr_d = psr_op;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_q    <= '0;
            shadow_q <= '0;
        end else begin
            psr_q    <= psr_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.psr = psr_q;

`ifdef FLAG_FWD_EN
    // Forwarded flags must still read 0 while reset is held.
    always_comb begin
        bus.C = !reset && psr_d[PSR_C];
        bus.L = !reset && psr_d[PSR_L];
        bus.F = !reset && psr_d[PSR_F];
        bus.N = !reset && psr_d[PSR_N];
        bus.Z = !reset && psr_d[PSR_Z];
        bus.E = !reset && psr_d[PSR_E];
    end
`else
    assign bus.C = psr_q[PSR_C];
    assign bus.L = psr_q[PSR_L];
    assign bus.F = psr_q[PSR_F];
    assign bus.N = psr_q[PSR_N];
    assign bus.Z = psr_q[PSR_Z];
    assign bus.E = psr_q[PSR_E];
`endif
endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed literal checks plus randomized
// traffic against an integer-arithmetic PSR model.
module tb_flag_unit;
    import flag_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    flag_unit_if #(.WIDTH(16)) bus ();

    flag_unit #(
        .WIDTH    (16),
        .PSR_MASK (16'h02E5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] m_psr;
    logic [15:0] m_sh;

    // Returns {shadow, psr} after one clock, from the architectural rules.
    function automatic logic [31:0] model_step(
        input logic [15:0] p, input logic [15:0] sh,
        input logic st, input logic v, input logic [2:0] cls,
        input logic [15:0] a, input logic [15:0] b,
        input logic ie, input logic ir);
        int ua, ub, sa, sb, cin, r;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        cin = 0;
        if (st) begin
        end else if (ir) begin
            p = sh;
        end else if (ie) begin
            sh = p;
            p[9] = 1'b0;
        end else if (v) begin
            case (cls)
                3'd1, 3'd2: begin
                    cin  = (cls == 3'd2 && p[0]) ? 1 : 0;
                    p[0] = (ua + ub + cin) > 65535;
                    r    = sa + sb + cin;
                    p[5] = (r > 32767) || (r < -32768);
                end
                3'd3, 3'd4: begin
                    cin  = (cls == 3'd4 && p[0]) ? 1 : 0;
                    p[0] = ua < (ub + cin);
                    r    = sa - sb - cin;
                    p[5] = (r > 32767) || (r < -32768);
                end
                3'd5: begin
                    p[6] = (ua == ub);
                    p[2] = (ub > ua);
                    p[7] = (sb > sa);
                end
                3'd6: p = a & 16'h02E5;
                3'd7: p[9] = b[0];
                default: ;
            endcase
        end
        return {sh, p};
    endfunction

    function automatic logic [15:0] flag_word();
        logic [15:0] w;
        w = '0;
        w[0] = bus.C; w[2] = bus.L; w[5] = bus.F;
        w[6] = bus.Z; w[7] = bus.N; w[9] = bus.E;
        return w;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_psr <= '0;
            m_sh  <= '0;
        end else begin
            {m_sh, m_psr} <= model_step(m_psr, m_sh, bus.stall, bus.op_valid, bus.op_class,
                                        bus.a, bus.b, bus.irq_entry, bus.irq_return);
        end
    end

    // Per-cycle compare of the registered PSR and the flag outputs.
    always @(negedge clk) begin
        logic [31:0] nx;
        logic [15:0] exp_flags;
        nx = model_step(m_psr, m_sh, bus.stall, bus.op_valid, bus.op_class,
                        bus.a, bus.b, bus.irq_entry, bus.irq_return);
`ifdef FLAG_FWD_EN
        exp_flags = reset ? 16'h0000 : nx[15:0];
`else
        exp_flags = m_psr;
`endif
        chk("cyc_psr", bus.psr, m_psr);
        chk("cyc_flags", flag_word(), exp_flags);
    end

    task automatic idle();
        bus.stall      = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op_class   = OP_NONE;
        bus.a          = '0;
        bus.b          = '0;
        bus.irq_entry  = 1'b0;
        bus.irq_return = 1'b0;
    endtask

    task automatic present(input op_class_t cls, input logic [15:0] a, input logic [15:0] b);
        bus.op_valid = 1'b1;
        bus.op_class = cls;
        bus.a        = a;
        bus.b        = b;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_op(input op_class_t cls, input logic [15:0] a, input logic [15:0] b);
        present(cls, a, b);
        commit();
    endtask

    task automatic lit(input string name, input logic [15:0] exp);
        chk({name, "_psr"}, bus.psr, exp);
        chk({name, "_flags"}, flag_word(), exp);
        chk({name, "_model"}, m_psr, exp);
    endtask

    function automatic logic [15:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 16'h0000);
        reset = 1'b0;

        do_op(OP_CMP, 16'h0003, 16'h0005);  lit("cmp_lt", 16'h0084);
        do_op(OP_CMP, 16'h8000, 16'h8000);  lit("cmp_eq", 16'h0040);
        do_op(OP_CMP, 16'h0001, 16'hFFFF);  lit("cmp_sgn", 16'h0004);
        do_op(OP_ADD, 16'hFFFF, 16'h0001);  lit("add_c", 16'h0005);
        do_op(OP_ADDC, 16'h7FFF, 16'h0000); lit("addc_f", 16'h0024);
        do_op(OP_SUB, 16'h0000, 16'h0001);  lit("sub_borrow", 16'h0005);
        do_op(OP_SUB, 16'h8000, 16'h0001);  lit("sub_f", 16'h0024);
        do_op(OP_SUB, 16'h0000, 16'h0001);  lit("sub_setc", 16'h0005);
        do_op(OP_SUBC, 16'h0010, 16'h0010); lit("subc_eq", 16'h0005);
        do_op(OP_LPR, 16'hFFFF, 16'h0000);  lit("lpr_mask", 16'h02E5);

        bus.stall = 1'b1;
        present(OP_CMP, 16'h0001, 16'h0002);
        @(posedge clk);
        #1;
        lit("stall_hold", 16'h02E5);
        idle();
        do_op(OP_CMP, 16'h0001, 16'h0002);  lit("stall_release", 16'h02A5);

        do_op(OP_LPR, 16'h0000, 16'h0000);  lit("lpr_zero", 16'h0000);
        do_op(OP_EDI, 16'h0000, 16'h0001);  lit("edi_set", 16'h0200);
        do_op(OP_CMP, 16'h0003, 16'h0005);  lit("pre_irq", 16'h0284);
        bus.irq_entry = 1'b1;
        present(OP_CMP, 16'h8000, 16'h8000);
        commit();                           lit("irq_entry", 16'h0084);
        bus.irq_return = 1'b1;
        commit();                           lit("irq_return", 16'h0284);

        do_op(OP_LPR, 16'h0001, 16'h0000);  lit("lpr_one", 16'h0001);
        bus.irq_entry = 1'b1;
        commit();                           lit("irq_entry2", 16'h0001);
        do_op(OP_LPR, 16'h00E0, 16'h0000);  lit("lpr_e0", 16'h00E0);
        bus.irq_entry  = 1'b1;
        bus.irq_return = 1'b1;
        commit();                           lit("irq_both", 16'h0001);
        do_op(OP_LPR, 16'h00E0, 16'h0000);
        bus.irq_return = 1'b1;
        commit();                           lit("shadow_kept", 16'h0001);

        do_op(OP_LPR, 16'h0000, 16'h0000);
        present(OP_CMP, 16'h0005, 16'h0005);
        #2;
`ifdef FLAG_FWD_EN
        chk("fwd_z_same_cycle", 16'(bus.Z), 16'h0001);
`else
        chk("fwd_z_same_cycle", 16'(bus.Z), 16'h0000);
`endif
        commit();                           lit("cmp_z_next", 16'h0040);

        do_op(OP_LPR, 16'hFFFF, 16'h0000);
        present(OP_CMP, 16'h0001, 16'h0002);
        #3;
        reset = 1'b1;
        #1;
        lit("async_reset", 16'h0000);
        @(posedge clk);
        #1;
        idle();
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 399) == 0);
            bus.stall      = ($urandom_range(0, 4) == 0);
            bus.op_valid   = ($urandom_range(0, 3) != 0);
            bus.op_class   = op_class_t'(3'($urandom_range(0, 7)));
            bus.a          = rnd_operand();
            bus.b          = ($urandom_range(0, 5) == 0) ? bus.a : rnd_operand();
            bus.irq_entry  = ($urandom_range(0, 15) == 0);
            bus.irq_return = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end

        idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
